// File: rtl/intr_ctrl.sv
// N-source interrupt controller: latches, masks and prioritises requests onto one INTR/INT_ACK pair.
// Serviced source and vector are frozen from ACK until software writes EOI.
module intr_ctrl #(
  parameter int          NUM_SRC   = 8,
  parameter logic [31:0] VEC_BASE  = 32'h0000_0200,
  parameter int          VEC_SHIFT = 2
) (
  input  logic               sys_clk,
  input  logic               reset,
  input  logic [NUM_SRC-1:0] irq_in,
  input  logic               IO_cs,
  input  logic               IO_rd,
  input  logic               IO_wr,
  input  logic [4:0]         io_addr,
  input  logic [31:0]        io_din,
  output logic [31:0]        io_dout,
  output logic               INTR,
  input  logic               INT_ACK,
  output logic [31:0]        int_vec
);

  // state   | meaning
  // IDLE    | no request outstanding
  // REQ     | INTR asserted, waiting for INT_ACK
  // SERVICE | source acknowledged, waiting for EOI write
  typedef enum logic [1:0] {IDLE, REQ, SERVICE} state_t;

  state_t             state, state_n;
  logic [NUM_SRC-1:0] irq_q, pend, mask, mode;
  logic [NUM_SRC-1:0] pend_n, act, rise, w1c, ack_clr;
  logic [7:0]         win, vec_idx;
  logic [2:0]         idx;
  logic               wr, rd, ack_go, eoi_go;
  logic [31:0]        rd_data;
  logic               unused_bits;

  assign idx         = io_addr[4:2];
  assign wr          = IO_cs & IO_wr;
  assign rd          = IO_cs & IO_rd;
  assign act         = pend & mask;
  assign INTR        = (state == REQ);
  assign unused_bits = ^{io_addr[1:0], io_din};

  always_comb begin
    win = 8'd0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (act[i]) win = 8'(i);
    end
  end

  always_comb begin
    state_n = state;
    ack_go  = 1'b0;
    eoi_go  = 1'b0;
    case (state)
      IDLE:    if (act != '0) state_n = REQ;
      REQ: begin
        if (INT_ACK) begin
          state_n = SERVICE;
          ack_go  = 1'b1;
        end else if (act == '0) begin
          state_n = IDLE;
        end
      end
      SERVICE: begin
        if (wr && idx == 3'd4) begin
          state_n = IDLE;
          eoi_go  = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Edge bits: a new rising edge beats W1C/ACK clears in the same cycle. Level bits track irq_q.
  always_comb begin
    rise    = irq_in & ~irq_q;
    w1c     = (wr && idx == 3'd0) ? io_din[NUM_SRC-1:0] : '0;
    ack_clr = ack_go ? (NUM_SRC'(1) << win) : '0;
    pend_n  = (mode & (rise | (pend & ~w1c & ~ack_clr))) | (~mode & irq_q);
  end

  always_comb begin
    rd_data = 32'd0;
    case (idx)
      3'd0:    rd_data = 32'(pend);
      3'd1:    rd_data = 32'(mask);
      3'd2:    rd_data = 32'(mode);
      3'd3:    rd_data = {(state == SERVICE), 23'd0, vec_idx};
      default: rd_data = 32'd0;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (reset) begin
      state   <= IDLE;
      irq_q   <= '0;
      pend    <= '0;
      mask    <= '0;
      mode    <= '0;
      vec_idx <= 8'd0;
      int_vec <= 32'd0;
      io_dout <= 32'd0;
    end else begin
      state <= state_n;
      irq_q <= irq_in;
      pend  <= pend_n;
      if (wr && idx == 3'd1) mask <= io_din[NUM_SRC-1:0];
      if (wr && idx == 3'd2) mode <= io_din[NUM_SRC-1:0];
      if (ack_go) begin
        vec_idx <= win;
        int_vec <= VEC_BASE + (32'(win) << VEC_SHIFT);
      end
      if (rd) io_dout <= rd_data;
    end
  end

endmodule

// File: tb/tb_intr_ctrl.sv
// Directed vector bench for intr_ctrl: one table row per clock, plus a hand-written latency/ACK sequence.
module tb_intr_ctrl;

  logic        sys_clk, reset, IO_cs, IO_rd, IO_wr, INTR, INT_ACK;
  logic [7:0]  irq_in;
  logic [4:0]  io_addr;
  logic [31:0] io_din, io_dout, int_vec;

  intr_ctrl #(.NUM_SRC(8), .VEC_BASE(32'h0000_0200), .VEC_SHIFT(2)) dut (
    .sys_clk(sys_clk), .reset(reset), .irq_in(irq_in),
    .IO_cs(IO_cs), .IO_rd(IO_rd), .IO_wr(IO_wr),
    .io_addr(io_addr), .io_din(io_din), .io_dout(io_dout),
    .INTR(INTR), .INT_ACK(INT_ACK), .int_vec(int_vec)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  // op: 0 = idle bus, 1 = write, 2 = read (e_dout checked only for reads)
  typedef struct {
    string       name;
    logic        rst;
    logic [7:0]  irq;
    logic        ack;
    logic [1:0]  op;
    logic [2:0]  idx;
    logic [31:0] din;
    logic        e_intr;
    logic [31:0] e_vec;
    logic [31:0] e_dout;
  } vec_t;

  vec_t tbl[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  task automatic add(input string name, input logic rst, input logic [7:0] irq, input logic ack,
                     input logic [1:0] op, input logic [2:0] idx, input logic [31:0] din,
                     input logic e_intr, input logic [31:0] e_vec, input logic [31:0] e_dout);
    vec_t v;
    v.name = name; v.rst = rst; v.irq = irq; v.ack = ack; v.op = op; v.idx = idx;
    v.din = din; v.e_intr = e_intr; v.e_vec = e_vec; v.e_dout = e_dout;
    tbl.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic bus_wr(input logic [2:0] idx, input logic [31:0] d);
    IO_cs = 1'b1; IO_wr = 1'b1; io_addr = {idx, 2'b00}; io_din = d;
    cyc();
    IO_cs = 1'b0; IO_wr = 1'b0; io_din = 32'd0;
  endtask

  initial begin
    int n;
    reset = 1'b1; irq_in = 8'h00; INT_ACK = 1'b0;
    IO_cs = 1'b0; IO_rd = 1'b0; IO_wr = 1'b0; io_addr = 5'd0; io_din = 32'd0;

    //   name           rst irq    ack op idx din           intr vec           dout
    add("t1_rst0",      1, 8'hFF, 0, 0, 0, 32'h0,        0, 32'h0,        32'h0);
    add("t1_rst1",      1, 8'hFF, 0, 0, 0, 32'h0,        0, 32'h0,        32'h0);
    add("t1_pend",      0, 8'h00, 0, 2, 0, 32'h0,        0, 32'h0,        32'h0);
    add("t1_mask",      0, 8'h00, 0, 2, 1, 32'h0,        0, 32'h0,        32'h0);
    add("t1_mode",      0, 8'h00, 0, 2, 2, 32'h0,        0, 32'h0,        32'h0);
    add("t2_wmask",     0, 8'h00, 0, 1, 1, 32'hFF,       0, 32'h0,        32'h0);
    add("t2_wmode",     0, 8'h00, 0, 1, 2, 32'hFF,       0, 32'h0,        32'h0);
    add("t2_irq3",      0, 8'h08, 0, 0, 0, 32'h0,        0, 32'h0,        32'h0);
    add("t2_intr",      0, 8'h00, 0, 0, 0, 32'h0,        1, 32'h0,        32'h0);
    add("t2_ack",       0, 8'h00, 1, 0, 0, 32'h0,        0, 32'h20C,      32'h0);
    add("t2_pend",      0, 8'h00, 0, 2, 0, 32'h0,        0, 32'h20C,      32'h0);
    add("t2_vec",       0, 8'h00, 0, 2, 3, 32'h0,        0, 32'h20C,      32'h8000_0003);
    add("t2_eoi",       0, 8'h00, 0, 1, 4, 32'h0,        0, 32'h20C,      32'h0);
    add("t2_idle",      0, 8'h00, 0, 0, 0, 32'h0,        0, 32'h20C,      32'h0);
    add("t3_irq52",     0, 8'h24, 0, 0, 0, 32'h0,        0, 32'h20C,      32'h0);
    add("t3_intr",      0, 8'h00, 0, 0, 0, 32'h0,        1, 32'h20C,      32'h0);
    add("t3_ack2",      0, 8'h00, 1, 0, 0, 32'h0,        0, 32'h208,      32'h0);
    add("t3_eoi",       0, 8'h00, 0, 1, 4, 32'h0,        0, 32'h208,      32'h0);
    add("t3_reintr",    0, 8'h00, 0, 0, 0, 32'h0,        1, 32'h208,      32'h0);
    add("t3_ack5",      0, 8'h00, 1, 0, 0, 32'h0,        0, 32'h214,      32'h0);
    add("t3_eoi5",      0, 8'h00, 0, 1, 4, 32'h0,        0, 32'h214,      32'h0);
    add("t3_idle",      0, 8'h00, 0, 0, 0, 32'h0,        0, 32'h214,      32'h0);
    add("pr_irq4",      0, 8'h10, 0, 0, 0, 32'h0,        0, 32'h214,      32'h0);
    add("pr_irq1_req",  0, 8'h02, 0, 0, 0, 32'h0,        1, 32'h214,      32'h0);
    add("pr_ack1",      0, 8'h00, 1, 0, 0, 32'h0,        0, 32'h204,      32'h0);
    add("pr_eoi",       0, 8'h00, 0, 1, 4, 32'h0,        0, 32'h204,      32'h0);
    add("pr_reintr",    0, 8'h00, 0, 0, 0, 32'h0,        1, 32'h204,      32'h0);
    add("pr_ack4",      0, 8'h00, 1, 0, 0, 32'h0,        0, 32'h210,      32'h0);
    add("pr_eoi4",      0, 8'h00, 0, 1, 4, 32'h0,        0, 32'h210,      32'h0);
    add("pr_idle",      0, 8'h00, 0, 0, 0, 32'h0,        0, 32'h210,      32'h0);
    add("t4_wmask0",    0, 8'h00, 0, 1, 1, 32'h00,       0, 32'h210,      32'h0);
    add("t4_wmode0",    0, 8'h00, 0, 1, 2, 32'h00,       0, 32'h210,      32'h0);
    add("t4_lvl_a",     0, 8'h01, 0, 0, 0, 32'h0,        0, 32'h210,      32'h0);
    add("t4_lvl_b",     0, 8'h01, 0, 0, 0, 32'h0,        0, 32'h210,      32'h0);
    add("t4_wmask1",    0, 8'h01, 0, 1, 1, 32'h01,       0, 32'h210,      32'h0);
    add("t4_intr",      0, 8'h01, 0, 0, 0, 32'h0,        1, 32'h210,      32'h0);
    add("t4_w1c",       0, 8'h01, 0, 1, 0, 32'h01,       1, 32'h210,      32'h0);
    add("t4_pend",      0, 8'h01, 0, 2, 0, 32'h0,        1, 32'h210,      32'h1);
    add("t5_wmask0",    0, 8'h01, 0, 1, 1, 32'h00,       1, 32'h210,      32'h0);
    add("t5_drop",      0, 8'h01, 0, 0, 0, 32'h0,        0, 32'h210,      32'h0);
    add("t5_vec",       0, 8'h01, 0, 2, 3, 32'h0,        0, 32'h210,      32'h0000_0004);
    add("t6_rel",       0, 8'h00, 0, 0, 0, 32'h0,        0, 32'h210,      32'h0);
    add("t6_wmode",     0, 8'h00, 0, 1, 2, 32'hFF,       0, 32'h210,      32'h0);
    add("t6_set_w1c",   0, 8'h02, 0, 1, 0, 32'h02,       0, 32'h210,      32'h0);
    add("t6_pend",      0, 8'h00, 0, 2, 0, 32'h0,        0, 32'h210,      32'h2);
    add("t6_wmask",     0, 8'h00, 0, 1, 1, 32'hFF,       0, 32'h210,      32'h0);
    add("t6_intr",      0, 8'h00, 0, 0, 0, 32'h0,        1, 32'h210,      32'h0);
    add("t6_ack",       0, 8'h00, 1, 0, 0, 32'h0,        0, 32'h204,      32'h0);
    add("t6_rst",       1, 8'h00, 0, 0, 0, 32'h0,        0, 32'h0,        32'h0);
    add("t6_eoi_late",  0, 8'h00, 0, 1, 4, 32'h0,        0, 32'h0,        32'h0);
    add("t6_mask",      0, 8'h00, 0, 2, 1, 32'h0,        0, 32'h0,        32'h0);
    add("t6_vecreg",    0, 8'h00, 0, 2, 3, 32'h0,        0, 32'h0,        32'h0);
    add("t6_pendreg",   0, 8'h00, 0, 2, 0, 32'h0,        0, 32'h0,        32'h0);

    foreach (tbl[k]) begin
      reset   = tbl[k].rst;
      irq_in  = tbl[k].irq;
      INT_ACK = tbl[k].ack;
      IO_cs   = (tbl[k].op != 2'd0);
      IO_wr   = (tbl[k].op == 2'd1);
      IO_rd   = (tbl[k].op == 2'd2);
      io_addr = {tbl[k].idx, 2'b00};
      io_din  = tbl[k].din;
      cyc();
      check({tbl[k].name, ".intr"}, {31'd0, INTR}, {31'd0, tbl[k].e_intr});
      check({tbl[k].name, ".vec"}, int_vec, tbl[k].e_vec);
      if (tbl[k].op == 2'd2) check({tbl[k].name, ".dout"}, io_dout, tbl[k].e_dout);
    end
    reset = 1'b0; irq_in = 8'h00; INT_ACK = 1'b0;
    IO_cs = 1'b0; IO_rd = 1'b0; IO_wr = 1'b0; io_din = 32'd0;

    // Edge-mode latency on source 7 measured with a bounded wait, then ACK/EOI.
    bus_wr(3'd1, 32'hFF);
    bus_wr(3'd2, 32'hFF);
    irq_in = 8'h80;
    cyc();
    irq_in = 8'h00;
    n = 1;
    while (!INTR && n < 10) begin
      cyc();
      n++;
    end
    check("lat7.cycles", n, 2);
    INT_ACK = 1'b1;
    cyc();
    INT_ACK = 1'b0;
    check("lat7.vec", int_vec, 32'h21C);
    check("lat7.intr_svc", {31'd0, INTR}, 32'd0);
    bus_wr(3'd4, 32'd0);
    cyc();
    check("lat7.intr_idle", {31'd0, INTR}, 32'd0);
    INT_ACK = 1'b1;
    cyc();
    INT_ACK = 1'b0;
    check("ack_idle.vec", int_vec, 32'h21C);

    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_fail);
    $finish;
  end

endmodule
